// File: rtl/mem_stage_if.sv
// mem_stage_if: execute/memory (XM) register handshake and payload feeding
// the memory-access stage.
//   master : XM register side (drives valid_i and the payload, sees ready_o)
//   slave  : mem_stage side (samples the payload, drives ready_o)
interface mem_stage_if;
  logic        valid_i;
  logic        ready_o;
  logic        zero_i;
  logic        ltz_i;
  logic [63:0] BranchPC_i;
  logic [63:0] result_i;
  logic [63:0] MuxRes_i;
  logic [4:0]  rd_i;
  logic        RegWrite_i;
  logic        MemWrite_i;
  logic        MemRead_i;
  logic        MemToReg_i;
  logic [2:0]  funct3_i;
  logic [2:0]  I_Type_i;

  modport master (
    output valid_i, zero_i, ltz_i, BranchPC_i, result_i, MuxRes_i, rd_i,
           RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i, funct3_i, I_Type_i,
    input  ready_o
  );

  modport slave (
    input  valid_i, zero_i, ltz_i, BranchPC_i, result_i, MuxRes_i, rd_i,
           RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i, funct3_i, I_Type_i,
    output ready_o
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV64 pipeline. Accepts one XM beat,
// resolves branches, issues loads/stores on the data-memory port and
// sign/zero-extends load data, presenting a registered valid/ready result
// toward the writeback register.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   xm                  XM handshake + payload (mem_stage_if.slave)
//   dmem_*              data-memory request/grant/response port
//   valid_o/ready_i     writeback-side handshake
//   rd_o, RegWrite_o, MemToReg_o, result_o, load_data_o   writeback payload
//   branch_taken_o, pipeline_flush_o, BranchPC_o           branch redirect
//   misalign_o          misaligned-access pulse
// Optional feature: define MEM_STAGE_MISALIGN_CHECK_EN to suppress misaligned
// accesses (no request, one-cycle misalign_o pulse, RegWrite_o forced to 0).
module mem_stage #(
  parameter logic [2:0] BranchType = 3'd3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  mem_stage_if.slave  xm,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [4:0]  rd_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [63:0] result_o,
  output logic [63:0] load_data_o,
  output logic        branch_taken_o,
  output logic        pipeline_flush_o,
  output logic [63:0] BranchPC_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, MIS} state_t;
  state_t state_q, state_d;

  logic        accept;
  logic        is_branch, br_cond, is_mem, mis_d;
  logic [2:0]  lane;
  logic [7:0]  size_mask, be_d;
  logic [63:0] rshift;
  logic [63:0] ext_data;

  logic [4:0]  rd_q;
  logic        rw_q, m2r_q, we_q, bt_q;
  logic [2:0]  lane_q, f3_q;
  logic [7:0]  be_q;
  logic [63:0] result_q, bpc_q, wdata_q, load_q;

  assign lane      = xm.result_i[2:0];
  assign is_branch = (xm.I_Type_i == BranchType);
  assign is_mem    = xm.MemRead_i | xm.MemWrite_i;

  always_comb begin
    br_cond = 1'b0;
    case (xm.funct3_i)
      3'b000:         br_cond = xm.zero_i;
      3'b001:         br_cond = !xm.zero_i;
      3'b100, 3'b110: br_cond = xm.ltz_i;
      3'b101, 3'b111: br_cond = !xm.ltz_i;
      default:        br_cond = 1'b0;
    endcase
  end

  always_comb begin
    size_mask = 8'h01;
    case (xm.funct3_i[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
  end

  // Lanes past byte 7 simply fall off the top of the 8-bit mask.
  assign be_d = size_mask << lane;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic lane_bad;
  always_comb begin
    lane_bad = 1'b0;
    case (xm.funct3_i[1:0])
      2'd0: lane_bad = 1'b0;
      2'd1: lane_bad = lane[0];
      2'd2: lane_bad = |lane[1:0];
      2'd3: lane_bad = |lane;
      default: lane_bad = 1'b0;
    endcase
  end
  assign mis_d      = is_mem & lane_bad;
  assign misalign_o = (state_q == MIS);
`else
  assign mis_d      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Load extension works on the captured lane/size, not the live XM inputs.
  assign rshift = dmem_rdata_i >> {lane_q, 3'b000};
  always_comb begin
    ext_data = rshift;
    case (f3_q)
      3'b000:  ext_data = {{56{rshift[7]}},  rshift[7:0]};
      3'b001:  ext_data = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  ext_data = {{32{rshift[31]}}, rshift[31:0]};
      3'b011:  ext_data = rshift;
      3'b100:  ext_data = {56'd0, rshift[7:0]};
      3'b101:  ext_data = {48'd0, rshift[15:0]};
      3'b110:  ext_data = {32'd0, rshift[31:0]};
      default: ext_data = rshift;
    endcase
  end

  // FULL accepts a new beat in the same cycle it drains, keeping ALU ops at
  // one per cycle.
  assign xm.ready_o = (state_q == IDLE) || (state_q == FULL && ready_i);
  assign accept     = xm.valid_i && xm.ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      REQ:     if (dmem_gnt_i) state_d = we_q ? FULL : WAIT;
      WAIT:    if (dmem_rvalid_i) state_d = FULL;
      MIS:     state_d = FULL;
      FULL:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (mis_d)       state_d = MIS;
      else if (is_mem) state_d = REQ;
      else             state_d = FULL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      we_q     <= 1'b0;
      bt_q     <= 1'b0;
      lane_q   <= '0;
      f3_q     <= '0;
      be_q     <= '0;
      result_q <= '0;
      bpc_q    <= '0;
      wdata_q  <= '0;
      load_q   <= '0;
    end else begin
      state_q <= state_d;
      bt_q    <= accept && is_branch && br_cond;
      if (accept) begin
        rd_q     <= xm.rd_i;
        rw_q     <= xm.RegWrite_i && (xm.rd_i != 5'd0) && !is_branch && !mis_d;
        m2r_q    <= xm.MemToReg_i;
        we_q     <= xm.MemWrite_i;
        lane_q   <= lane;
        f3_q     <= xm.funct3_i;
        be_q     <= be_d;
        result_q <= xm.result_i;
        bpc_q    <= xm.BranchPC_i;
        wdata_q  <= xm.MuxRes_i << {lane, 3'b000};
        load_q   <= '0;
      end else if (state_q == WAIT && dmem_rvalid_i) begin
        load_q <= ext_data;
      end
    end
  end

  assign dmem_req_o       = (state_q == REQ);
  assign dmem_we_o        = (state_q == REQ) && we_q;
  assign dmem_addr_o      = {result_q[63:3], 3'b000};
  assign dmem_wdata_o     = wdata_q;
  assign dmem_be_o        = be_q;
  assign valid_o          = (state_q == FULL);
  assign rd_o             = rd_q;
  assign RegWrite_o       = rw_q;
  assign MemToReg_o       = m2r_q;
  assign result_o         = result_q;
  assign load_data_o      = load_q;
  assign branch_taken_o   = bt_q;
  assign pipeline_flush_o = bt_q;
  assign BranchPC_o       = bpc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven bench for mem_stage. ALU/branch beats
// come from a vector table streamed back-to-back; loads, stores, stalls,
// reset-in-WAIT and the misalignment corner are hand-written sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [63:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [7:0]  dmem_be_o;
  logic        valid_o, ready_i;
  logic [4:0]  rd_o;
  logic        RegWrite_o, MemToReg_o;
  logic [63:0] result_o, load_data_o, BranchPC_o;
  logic        branch_taken_o, pipeline_flush_o, misalign_o;

  int tests = 0;
  int fails = 0;

  mem_stage_if xm ();

  mem_stage #(.BranchType(3'd3)) dut (
    .clk_i(clk), .reset_i(reset_i), .xm(xm),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .rd_o(rd_o),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .result_o(result_o), .load_data_o(load_data_o),
    .branch_taken_o(branch_taken_o), .pipeline_flush_o(pipeline_flush_o),
    .BranchPC_o(BranchPC_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  itype;
    logic [2:0]  f3;
    logic        zero;
    logic        ltz;
    logic [63:0] bpc;
    logic        exp_rw;
    logic        exp_bt;
  } alu_vec_t;

  alu_vec_t vec [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    xm.valid_i = 0; xm.zero_i = 0; xm.ltz_i = 0; xm.BranchPC_i = '0;
    xm.result_i = '0; xm.MuxRes_i = '0; xm.rd_i = '0; xm.RegWrite_i = 0;
    xm.MemWrite_i = 0; xm.MemRead_i = 0; xm.MemToReg_i = 0;
    xm.funct3_i = '0; xm.I_Type_i = '0;
  endtask

  task automatic drive_vec(input alu_vec_t v);
    clr_in();
    xm.valid_i = 1; xm.result_i = v.res; xm.rd_i = v.rd; xm.RegWrite_i = v.rw;
    xm.I_Type_i = v.itype; xm.funct3_i = v.f3; xm.zero_i = v.zero;
    xm.ltz_i = v.ltz; xm.BranchPC_i = v.bpc;
  endtask

  task automatic check_vec(input int i);
    chk($sformatf("vec%0d valid_o", i), 64'(valid_o), 64'd1);
    chk($sformatf("vec%0d ready_o", i), 64'(xm.ready_o), 64'd1);
    chk($sformatf("vec%0d result_o", i), result_o, vec[i].res);
    chk($sformatf("vec%0d RegWrite_o", i), 64'(RegWrite_o), 64'(vec[i].exp_rw));
    chk($sformatf("vec%0d branch_taken_o", i), 64'(branch_taken_o), 64'(vec[i].exp_bt));
    chk($sformatf("vec%0d pipeline_flush_o", i), 64'(pipeline_flush_o), 64'(vec[i].exp_bt));
    if (vec[i].exp_bt) chk($sformatf("vec%0d BranchPC_o", i), BranchPC_o, vec[i].bpc);
  endtask

  // Store with a programmable grant delay; request must hold steady meanwhile.
  task automatic do_store(input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] data, input int gdly,
                          input logic [7:0] exp_be, input logic [63:0] exp_wd);
    @(negedge clk);
    clr_in();
    xm.valid_i = 1; xm.MemWrite_i = 1; xm.funct3_i = f3;
    xm.result_i = addr; xm.MuxRes_i = data;
    @(negedge clk);
    xm.valid_i = 0;
    chk("st ready_o busy", 64'(xm.ready_o), 64'd0);
    for (int k = 0; k <= gdly; k++) begin
      chk($sformatf("st req c%0d", k), 64'(dmem_req_o), 64'd1);
      chk($sformatf("st we c%0d", k), 64'(dmem_we_o), 64'd1);
      chk($sformatf("st be c%0d", k), 64'(dmem_be_o), 64'(exp_be));
      chk($sformatf("st addr c%0d", k), dmem_addr_o, {addr[63:3], 3'b000});
      chk($sformatf("st wdata c%0d", k), dmem_wdata_o, exp_wd);
      chk($sformatf("st valid_o c%0d", k), 64'(valid_o), 64'd0);
      if (k < gdly) @(negedge clk);
    end
    dmem_gnt_i = 1;
    @(negedge clk);
    dmem_gnt_i = 0;
    chk("st valid_o", 64'(valid_o), 64'd1);
    chk("st req dropped", 64'(dmem_req_o), 64'd0);
    chk("st RegWrite_o", 64'(RegWrite_o), 64'd0);
    @(negedge clk);
    chk("st drained", 64'(valid_o), 64'd0);
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] exp);
    @(negedge clk);
    clr_in();
    xm.valid_i = 1; xm.MemRead_i = 1; xm.MemToReg_i = 1; xm.RegWrite_i = 1;
    xm.rd_i = 5'd10; xm.funct3_i = f3; xm.result_i = addr;
    @(negedge clk);
    xm.valid_i = 0;
    chk({nm, " req"}, 64'(dmem_req_o), 64'd1);
    chk({nm, " we"}, 64'(dmem_we_o), 64'd0);
    chk({nm, " addr"}, dmem_addr_o, {addr[63:3], 3'b000});
    dmem_gnt_i = 1;
    @(negedge clk);
    dmem_gnt_i = 0;
    chk({nm, " wait req"}, 64'(dmem_req_o), 64'd0);
    chk({nm, " wait valid_o"}, 64'(valid_o), 64'd0);
    dmem_rvalid_i = 1; dmem_rdata_i = rdata;
    @(negedge clk);
    dmem_rvalid_i = 0;
    chk({nm, " valid_o"}, 64'(valid_o), 64'd1);
    chk({nm, " load_data_o"}, load_data_o, exp);
    chk({nm, " RegWrite_o"}, 64'(RegWrite_o), 64'd1);
    chk({nm, " MemToReg_o"}, 64'(MemToReg_o), 64'd1);
    chk({nm, " rd_o"}, 64'(rd_o), 64'd10);
    @(negedge clk);
  endtask

  initial begin
    //        res                     rd  rw itype f3    z  l  bpc        erw ebt
    vec[0] = '{64'h1234,              5,  1, 3'd0, 3'd0, 0, 0, 64'h0,     1, 0}; // ADD
    vec[1] = '{64'h55,                0,  1, 3'd0, 3'd0, 0, 0, 64'h0,     0, 0}; // rd=0
    vec[2] = '{64'h1,                 0,  0, 3'd3, 3'd1, 0, 0, 64'h400,   0, 1}; // BNE taken
    vec[3] = '{64'h1,                 0,  0, 3'd3, 3'd0, 0, 0, 64'h500,   0, 0}; // BEQ not
    vec[4] = '{64'h2,                 0,  0, 3'd3, 3'd4, 0, 1, 64'h800,   0, 1}; // BLT taken
    vec[5] = '{64'h3,                 0,  0, 3'd3, 3'd5, 0, 1, 64'h900,   0, 0}; // BGE not
    vec[6] = '{64'h0,                 7,  1, 3'd3, 3'd0, 1, 0, 64'h40,    0, 1}; // BEQ taken, rw masked
    vec[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 31, 1, 3'd0, 3'd0, 0, 0, 64'h0,   1, 0};

    clr_in();
    reset_i = 1; ready_i = 1; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    reset_i = 0;
    chk("rst ready_o", 64'(xm.ready_o), 64'd1);
    chk("rst valid_o", 64'(valid_o), 64'd0);
    chk("rst dmem_req_o", 64'(dmem_req_o), 64'd0);
    chk("rst dmem_we_o", 64'(dmem_we_o), 64'd0);
    chk("rst dmem_be_o", 64'(dmem_be_o), 64'd0);
    chk("rst dmem_addr_o", dmem_addr_o, 64'd0);
    chk("rst dmem_wdata_o", dmem_wdata_o, 64'd0);
    chk("rst result_o", result_o, 64'd0);
    chk("rst load_data_o", load_data_o, 64'd0);
    chk("rst BranchPC_o", BranchPC_o, 64'd0);
    chk("rst branch_taken_o", 64'(branch_taken_o), 64'd0);
    chk("rst misalign_o", 64'(misalign_o), 64'd0);
    chk("rst RegWrite_o", 64'(RegWrite_o), 64'd0);

    // Back-to-back ALU/branch stream: one beat accepted per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) check_vec(i - 1);
      drive_vec(vec[i]);
    end
    @(negedge clk);
    check_vec(7);
    clr_in();
    @(negedge clk);
    chk("stream drained valid_o", 64'(valid_o), 64'd0);
    chk("stream no pulse", 64'(branch_taken_o), 64'd0);

    // Single taken branch: pulse lasts exactly one cycle.
    @(negedge clk);
    drive_vec(vec[2]);
    ready_i = 0;
    @(negedge clk);
    clr_in();
    chk("bne pulse", 64'(branch_taken_o), 64'd1);
    @(negedge clk);
    chk("bne pulse gone", 64'(branch_taken_o), 64'd0);
    chk("bne flush gone", 64'(pipeline_flush_o), 64'd0);
    chk("bne still valid", 64'(valid_o), 64'd1);
    ready_i = 1;
    @(negedge clk);

    // Writeback stall: outputs frozen while ready_i is low.
    @(negedge clk);
    clr_in();
    xm.valid_i = 1; xm.result_i = 64'hBEEF; xm.rd_i = 3; xm.RegWrite_i = 1;
    ready_i = 0;
    @(negedge clk);
    clr_in();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall valid_o c%0d", k), 64'(valid_o), 64'd1);
      chk($sformatf("stall ready_o c%0d", k), 64'(xm.ready_o), 64'd0);
      chk($sformatf("stall result_o c%0d", k), result_o, 64'hBEEF);
      @(negedge clk);
    end
    ready_i = 1;
    @(negedge clk);
    chk("stall released", 64'(valid_o), 64'd0);

    // Stores.
    do_store(3'd0, 64'h1003, 64'hAB, 3, 8'h08, 64'hAB00_0000);
    do_store(3'd3, 64'h1008, 64'h0123_4567_89AB_CDEF, 0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    do_store(3'd1, 64'h1006, 64'hBEEF, 1, 8'hC0, 64'hBEEF_0000_0000_0000);

    // Loads.
    do_load("lb",  3'd0, 64'h2001, 64'h0000_0000_0000_80FF, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", 3'd4, 64'h2001, 64'h0000_0000_0000_80FF, 64'h80);
    do_load("lh",  3'd1, 64'h2002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lwu", 3'd6, 64'h2004, 64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF);
    do_load("ld",  3'd3, 64'h2008, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

    // Reset while waiting for read data; the late response must be dropped.
    @(negedge clk);
    clr_in();
    xm.valid_i = 1; xm.MemRead_i = 1; xm.RegWrite_i = 1; xm.rd_i = 9;
    xm.funct3_i = 3'd3; xm.result_i = 64'h2010;
    @(negedge clk);
    clr_in();
    dmem_gnt_i = 1;
    @(negedge clk);
    dmem_gnt_i = 0;
    reset_i = 1;
    @(negedge clk);
    reset_i = 0;
    chk("rstw ready_o", 64'(xm.ready_o), 64'd1);
    dmem_rvalid_i = 1; dmem_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    dmem_rvalid_i = 0;
    chk("rstw valid_o", 64'(valid_o), 64'd0);
    chk("rstw load_data_o", load_data_o, 64'd0);
    @(negedge clk);
    chk("rstw valid_o later", 64'(valid_o), 64'd0);
    chk("rstw req", 64'(dmem_req_o), 64'd0);

    // Misaligned lw at 0x3002.
    @(negedge clk);
    clr_in();
    xm.valid_i = 1; xm.MemRead_i = 1; xm.MemToReg_i = 1; xm.RegWrite_i = 1;
    xm.rd_i = 4; xm.funct3_i = 3'd2; xm.result_i = 64'h3002;
    @(negedge clk);
    clr_in();
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    chk("mis req", 64'(dmem_req_o), 64'd0);
    chk("mis pulse", 64'(misalign_o), 64'd1);
    chk("mis valid_o early", 64'(valid_o), 64'd0);
    @(negedge clk);
    chk("mis pulse gone", 64'(misalign_o), 64'd0);
    chk("mis valid_o", 64'(valid_o), 64'd1);
    chk("mis RegWrite_o", 64'(RegWrite_o), 64'd0);
    chk("mis req late", 64'(dmem_req_o), 64'd0);
    @(negedge clk);
`else
    chk("mis req", 64'(dmem_req_o), 64'd1);
    chk("mis be", 64'(dmem_be_o), 64'h3C);
    chk("mis addr", dmem_addr_o, 64'h3000);
    chk("mis pulse", 64'(misalign_o), 64'd0);
    dmem_gnt_i = 1;
    @(negedge clk);
    dmem_gnt_i = 0;
    dmem_rvalid_i = 1; dmem_rdata_i = 64'h0000_1234_5678_0000;
    @(negedge clk);
    dmem_rvalid_i = 0;
    chk("mis valid_o", 64'(valid_o), 64'd1);
    chk("mis load_data_o", load_data_o, 64'h1234_5678);
    chk("mis RegWrite_o", 64'(RegWrite_o), 64'd1);
    @(negedge clk);
`endif
    chk("end idle", 64'(valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
